// File: rtl/bomberman_draw_scheduler.sv
// bomberman_draw_scheduler
//   Frame-level sequencer for the bomberman datapath. Each frame it redraws the
//   11x11 stage tile by tile, then sprite P1, then sprite P2, waits for the frame
//   tick, and on every MOVE_DIV-th tick applies one latched move per player.
//
// Ports
//   clock, reset          system clock, asynchronous active-high reset
//   start                 level; leaves IDLE and begins the game
//   frame_tick            one-cycle pulse per display frame
//   finished              copy-engine done pulse
//   all_tiles_drawn       tile counters back at (0,0)
//   p1_keys, p2_keys      {bomb,xdir,xmov,ydir,ymov} raw player requests
//   memory_select         0 tile ROM, 1 P1 sprite, 2 P2 sprite
//   copy_enable           held high until the copy finishes
//   tc_enable             one-cycle tile-counter advance
//   draw_t/draw_p1/draw_p2  coordinate source selects
//   player_reset, stage_reset  high in reset and IDLE
//   p1_move, p2_move      latched moves, non-zero only in the MOVE cycle
//   busy                  high outside IDLE and WAIT_FRAME
//   timeout_err           sticky copy-timeout flag
//
// Build option
//   COPY_TIMEOUT_EN  enables the per-copy timeout counter; when undefined the
//                    COPY states wait indefinitely and timeout_err is tied 0.
//
// All outputs are registered from a decode of the next state, so they line up
// with the state the FSM is in and drop asynchronously with reset.

module bomberman_draw_scheduler #(
  parameter int unsigned MOVE_DIV     = 4,
  parameter int unsigned COPY_TIMEOUT = 1023
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       frame_tick,
  input  logic       finished,
  input  logic       all_tiles_drawn,
  input  logic [4:0] p1_keys,
  input  logic [4:0] p2_keys,
  output logic [1:0] memory_select,
  output logic       copy_enable,
  output logic       tc_enable,
  output logic       draw_t,
  output logic       draw_p1,
  output logic       draw_p2,
  output logic       player_reset,
  output logic       stage_reset,
  output logic [4:0] p1_move,
  output logic [4:0] p2_move,
  output logic       busy,
  output logic       timeout_err
);

  localparam int unsigned DIV_W = 4;
  localparam int unsigned KEY_W = 5;
  localparam int unsigned SEL_W = 2;

  // Reject parameter values the divider or timeout counter cannot represent.
  if (MOVE_DIV < 1 || MOVE_DIV > 15 || COPY_TIMEOUT < 1) begin : g_param_check
    $error("bomberman_draw_scheduler: MOVE_DIV must be 1..15 and COPY_TIMEOUT >= 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_T_SETUP, S_T_COPY, S_T_NEXT, S_T_CHECK,
    S_P1_SETUP, S_P1_COPY, S_P2_SETUP, S_P2_COPY,
    S_WAIT_FRAME, S_MOVE
  } state_t;

  state_t             state, state_next;
  logic [DIV_W-1:0]   div_q, div_next;
  logic [KEY_W-1:0]   p1_lat, p2_lat;
  logic [KEY_W-1:0]   p1_acc, p2_acc;
  logic               copy_done;

  logic [SEL_W-1:0]   memory_select_d;
  logic               copy_enable_d, tc_enable_d, draw_t_d, draw_p1_d, draw_p2_d;
  logic               resets_d, busy_d;

  // OR-accumulate requests; a direction bit follows the latest sample taken
  // while its movement bit was high.
  function automatic logic [KEY_W-1:0] key_acc(input logic [KEY_W-1:0] lat,
                                               input logic [KEY_W-1:0] k);
    logic [KEY_W-1:0] r;
    r    = lat;
    r[4] = lat[4] | k[4];
    r[2] = lat[2] | k[2];
    if (k[2]) r[3] = k[3];
    r[0] = lat[0] | k[0];
    if (k[0]) r[1] = k[1];
    return r;
  endfunction

  assign p1_acc = key_acc(p1_lat, p1_keys);
  assign p2_acc = key_acc(p2_lat, p2_keys);

`ifdef COPY_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(COPY_TIMEOUT + 1);

  logic [TO_W-1:0] to_cnt;
  logic            in_copy;
  logic            to_hit;

  assign in_copy   = (state == S_T_COPY) || (state == S_P1_COPY) || (state == S_P2_COPY);
  assign to_hit    = in_copy && !finished && (to_cnt == TO_W'(COPY_TIMEOUT - 1));
  assign copy_done = finished || to_hit;

  // Per-copy cycle counter; restarts on every COPY entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt      <= in_copy ? to_cnt + TO_W'(1) : '0;
      timeout_err <= timeout_err | to_hit;
    end
  end
`else
  assign copy_done   = finished;
  assign timeout_err = 1'b0;
`endif

  // Next state, divider update and next-state output decode.
  always_comb begin
    state_next      = state;
    div_next        = div_q;
    memory_select_d = '0;
    copy_enable_d   = 1'b0;
    tc_enable_d     = 1'b0;
    draw_t_d        = 1'b0;
    draw_p1_d       = 1'b0;
    draw_p2_d       = 1'b0;
    resets_d        = 1'b0;
    busy_d          = 1'b1;

    case (state)
      S_IDLE:       if (start) state_next = S_T_SETUP;
      S_T_SETUP:    state_next = S_T_COPY;
      S_T_COPY:     if (copy_done) state_next = S_T_NEXT;
      S_T_NEXT:     state_next = S_T_CHECK;
      // Counters idle at (0,0), so the flag is only meaningful after an advance.
      S_T_CHECK:    state_next = all_tiles_drawn ? S_P1_SETUP : S_T_SETUP;
      S_P1_SETUP:   state_next = S_P1_COPY;
      S_P1_COPY:    if (copy_done) state_next = S_P2_SETUP;
      S_P2_SETUP:   state_next = S_P2_COPY;
      S_P2_COPY:    if (copy_done) state_next = S_WAIT_FRAME;
      S_WAIT_FRAME: begin
        if (frame_tick) begin
          if (div_q == DIV_W'(MOVE_DIV - 1)) begin
            div_next   = '0;
            state_next = S_MOVE;
          end else begin
            div_next   = div_q + DIV_W'(1);
            state_next = S_T_SETUP;
          end
        end
      end
      S_MOVE:       state_next = S_T_SETUP;
      default:      state_next = S_IDLE;
    endcase

    case (state_next)
      S_IDLE: begin
        resets_d = 1'b1;
        busy_d   = 1'b0;
      end
      S_T_SETUP:  draw_t_d = 1'b1;
      S_T_COPY: begin
        draw_t_d      = 1'b1;
        copy_enable_d = 1'b1;
      end
      S_T_NEXT: begin
        draw_t_d    = 1'b1;
        tc_enable_d = 1'b1;
      end
      S_P1_SETUP: begin
        draw_p1_d       = 1'b1;
        memory_select_d = SEL_W'(1);
      end
      S_P1_COPY: begin
        draw_p1_d       = 1'b1;
        memory_select_d = SEL_W'(1);
        copy_enable_d   = 1'b1;
      end
      S_P2_SETUP: begin
        draw_p2_d       = 1'b1;
        memory_select_d = SEL_W'(2);
      end
      S_P2_COPY: begin
        draw_p2_d       = 1'b1;
        memory_select_d = SEL_W'(2);
        copy_enable_d   = 1'b1;
      end
      S_WAIT_FRAME: busy_d = 1'b0;
      default: ;
    endcase
  end

  // State, divider, key latches and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      div_q         <= '0;
      p1_lat        <= '0;
      p2_lat        <= '0;
      memory_select <= '0;
      copy_enable   <= 1'b0;
      tc_enable     <= 1'b0;
      draw_t        <= 1'b0;
      draw_p1       <= 1'b0;
      draw_p2       <= 1'b0;
      player_reset  <= 1'b1;
      stage_reset   <= 1'b1;
      p1_move       <= '0;
      p2_move       <= '0;
      busy          <= 1'b0;
    end else begin
      state         <= state_next;
      div_q         <= div_next;
      memory_select <= memory_select_d;
      copy_enable   <= copy_enable_d;
      tc_enable     <= tc_enable_d;
      draw_t        <= draw_t_d;
      draw_p1       <= draw_p1_d;
      draw_p2       <= draw_p2_d;
      player_reset  <= resets_d;
      stage_reset   <= resets_d;
      busy          <= busy_d;

      // Keys seen on the tick cycle still count toward the move being issued.
      if (state_next == S_MOVE) begin
        p1_move <= p1_acc;
        p2_move <= p2_acc;
      end else begin
        p1_move <= '0;
        p2_move <= '0;
      end

      // Latches clear entering MOVE; keys during the MOVE cycle are discarded.
      if (state == S_MOVE || state_next == S_MOVE) begin
        p1_lat <= '0;
        p2_lat <= '0;
      end else begin
        p1_lat <= p1_acc;
        p2_lat <= p2_acc;
      end
    end
  end

endmodule

// File: tb/tb_bomberman_draw_scheduler.sv
// Directed bench for bomberman_draw_scheduler with a tile-counter / copy-engine
// model and a move scoreboard.

module tb_bomberman_draw_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       finished = 1'b0;
  logic       all_tiles_drawn;
  logic [4:0] p1_keys = '0;
  logic [4:0] p2_keys = '0;
  logic [1:0] memory_select;
  logic       copy_enable, tc_enable, draw_t, draw_p1, draw_p2;
  logic       player_reset, stage_reset, busy, timeout_err;
  logic [4:0] p1_move, p2_move;

  bomberman_draw_scheduler #(.MOVE_DIV(4), .COPY_TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .start(start), .frame_tick(frame_tick),
    .finished(finished), .all_tiles_drawn(all_tiles_drawn),
    .p1_keys(p1_keys), .p2_keys(p2_keys), .memory_select(memory_select),
    .copy_enable(copy_enable), .tc_enable(tc_enable), .draw_t(draw_t),
    .draw_p1(draw_p1), .draw_p2(draw_p2), .player_reset(player_reset),
    .stage_reset(stage_reset), .p1_move(p1_move), .p2_move(p2_move),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Datapath tile counter: 11x11, advanced by tc_enable, cleared by reset.
  int tx, ty;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      tx <= 0;
      ty <= 0;
    end else if (tc_enable) begin
      if (tx == 10) begin
        tx <= 0;
        ty <= (ty == 10) ? 0 : ty + 1;
      end else begin
        tx <= tx + 1;
      end
    end
  end
  assign all_tiles_drawn = (tx == 0) && (ty == 0);

  // Copy engine: finished pulses on the fin_delay-th cycle of copy_enable
  // (1 = the same cycle copy_enable rises, 0 = never).
  int fin_delay = 3;
  int cyc = 0;
  always @(negedge clock) begin
    if (copy_enable) begin
      cyc++;
      finished = (fin_delay != 0) && (cyc == fin_delay);
    end else begin
      cyc = 0;
      finished = 1'b0;
    end
  end

  // Monitor: strobe counting and move scoreboard.
  logic [9:0] exp_q[$];
  logic [9:0] mon_e;
  int   tc_count = 0, tile_eps = 0, p1_eps = 0, p2_eps = 0, move_count = 0;
  int   ep_seq = 0, p1_seq = 0, p2_seq = 0, p1_rise_tc = 0, p2_rise_tc = 0;
  int   ce_len = 0, last_ce_len = 0;
  logic prev_ce = 1'b0, prev_wait = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      prev_ce   = 1'b0;
      prev_wait = 1'b0;
      ce_len    = 0;
    end else begin
      if (tc_enable) tc_count++;
      if (copy_enable && !prev_ce) begin
        ep_seq++;
        if (draw_t) tile_eps++;
        if (draw_p1) begin
          p1_eps++; p1_seq = ep_seq; p1_rise_tc = tc_count;
          chk("p1_memory_select", 32'(memory_select), 1);
        end
        if (draw_p2) begin
          p2_eps++; p2_seq = ep_seq; p2_rise_tc = tc_count;
          chk("p2_memory_select", 32'(memory_select), 2);
        end
      end
      if (copy_enable) ce_len++;
      else if (prev_ce) begin
        last_ce_len = ce_len;
        ce_len = 0;
      end
      // MOVE is the only busy cycle straight after WAIT_FRAME without draw_t.
      if (prev_wait && busy && !draw_t) begin
        move_count++;
        if (exp_q.size() == 0) begin
          chk("move_unexpected", 32'({p1_move, p2_move}), 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("p1_move", 32'(p1_move), 32'(mon_e[9:5]));
          chk("p2_move", 32'(p2_move), 32'(mon_e[4:0]));
        end
      end
      prev_ce   = copy_enable;
      prev_wait = !busy && !player_reset;
    end
  end

  task automatic tick();
    @(negedge clock) frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(!busy && !player_reset) && n < 3000);
    chk(tag, 32'(!busy && !player_reset), 1);
  endtask

  int t0, e0, m0, n;

  initial begin
    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_player_reset", 32'(player_reset), 1);
    chk("rst_stage_reset", 32'(stage_reset), 1);
    chk("rst_copy_enable", 32'(copy_enable), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_err", 32'(timeout_err), 0);
    chk("rst_moves", 32'({p1_move, p2_move, memory_select, tc_enable, draw_t}), 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("idle_hold", 32'({player_reset, busy}), 32'(2'b10));

    // First frame; start dropped mid-frame must not matter
    start = 1'b1;
    repeat (100) @(negedge clock);
    start = 1'b0;
    wait_frame("f1_wait_frame");
    chk("f1_tc_pulses", tc_count, 121);
    chk("f1_tile_copies", tile_eps, 121);
    chk("f1_p1_copies", p1_eps, 1);
    chk("f1_p2_copies", p2_eps, 1);
    chk("f1_p1_after_tiles", p1_rise_tc, 121);
    chk("f1_p2_after_p1", p2_seq - p1_seq, 1);
    chk("f1_wait_outputs", 32'({copy_enable, draw_t, draw_p1, draw_p2}), 0);

    // Held p1 x-move over 8 ticks: moves on ticks 4 and 8
    p1_keys = 5'b01100;
    exp_q.push_back({5'b01100, 5'b00000});
    exp_q.push_back({5'b01100, 5'b00000});
    m0 = move_count;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) p1_keys = '0;
      wait_frame("p1x_wait_frame");
    end
    chk("p1x_move_count", move_count - m0, 2);
    chk("p1x_queue_empty", exp_q.size(), 0);
    chk("p1x_move_idle", 32'(p1_move), 0);

    // p2 ymov pulse during redraw plus a frame_tick during P1_COPY
    m0 = move_count;
    tick();
    repeat (50) @(negedge clock);
    chk("p2y_in_redraw", 32'(draw_t), 1);
    p2_keys = 5'b00001;
    exp_q.push_back({5'b00000, 5'b00001});
    exp_q.push_back({5'b00000, 5'b00000});
    @(negedge clock) p2_keys = '0;
    wait_frame("p2y_wait_frame1");
    tick();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(draw_p1 && copy_enable) && n < 3000);
    chk("spur_reach_p1_copy", 32'(draw_p1 && copy_enable), 1);
    frame_tick = 1'b1;
    @(negedge clock) frame_tick = 1'b0;
    wait_frame("spur_wait_frame");
    t0 = tc_count;
    repeat (5) @(negedge clock);
    chk("spur_still_waiting", 32'(busy), 0);
    chk("spur_no_redraw", tc_count - t0, 0);
    for (int i = 2; i < 8; i++) begin
      tick();
      wait_frame("p2y_wait_frame");
    end
    chk("p2y_move_count", move_count - m0, 2);
    chk("p2y_queue_empty", exp_q.size(), 0);

    // finished in the same cycle copy_enable rises
    fin_delay = 1;
    t0 = tc_count;
    e0 = tile_eps;
    tick();
    wait_frame("fast_wait_frame");
    chk("fast_tc_pulses", tc_count - t0, 121);
    chk("fast_tile_copies", tile_eps - e0, 121);
    chk("fast_copy_len", last_ce_len, 1);
    fin_delay = 3;

    // Reset during the copy of tile 37
    e0 = tile_eps;
    tick();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!((tile_eps - e0) == 37 && copy_enable) && n < 3000);
    chk("mid_reach_tile37", 32'((tile_eps - e0) == 37 && copy_enable), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_copy_enable", 32'(copy_enable), 0);
    chk("mid_player_reset", 32'(player_reset), 1);
    chk("mid_stage_reset", 32'(stage_reset), 1);
    chk("mid_strobes", 32'({busy, tc_enable, draw_t}), 0);
    @(negedge clock) reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("mid_idle_hold", 32'({player_reset, busy}), 32'(2'b10));
    t0 = tc_count;
    start = 1'b1;
    wait_frame("mid_restart_frame");
    chk("mid_restart_tc", tc_count - t0, 121);

`ifdef COPY_TIMEOUT_EN
    // Copy that never finishes times out after 16 cycles
    chk("to_err_clear", 32'(timeout_err), 0);
    fin_delay = 0;
    tick();
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!copy_enable && n < 100);
    do begin
      @(negedge clock);
      n++;
    end while (copy_enable && n < 200);
    fin_delay = 3;
    #1;
    chk("to_copy_len", last_ce_len, 16);
    chk("to_err_set", 32'(timeout_err), 1);
    chk("to_tc_next", 32'(tc_enable), 1);
    wait_frame("to_wait_frame");
    chk("to_err_sticky", 32'(timeout_err), 1);
`else
    chk("to_err_tied", 32'(timeout_err), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
